sevenseg_scan: RTL and testbench

Time-multiplexed scanner for an NDIGITS-digit common-anode seven-segment display. It holds a frame value of packed hex nibbles plus per-digit decimal points and steps through the digits at a fixed refresh rate. For each digit slot it presents a 4-bit digit, a decimal point, a blank flag and a one-hot digit enable. It sits directly upstream of the hex-to-segment decoder, which turns `digit` into the pabcdefg pattern; `blank` and `dp` gate that pattern at the top level.

---
 rtl/display_pkg.sv | 26 ++
 rtl/scan_tick_gen.sv | 40 ++++
 rtl/sevenseg_scan.sv | 91 +++++++++
 tb/tb_sevenseg_scan.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared helpers for the display path: nibble width, digit-enable decode and
// leading-zero detection over a packed hex frame (sized for up to 8 digits).
package display_pkg;

   localparam int NIBBLE_W   = 4;
   localparam int MAX_DIGITS = 8;

   function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] slot);
      onehot       = '0;
      onehot[slot] = 1'b1;
   endfunction

   // Bit i is set when nibbles i..MAX_DIGITS-1 are all zero; narrower frames
   // are zero-extended, so their unused upper nibbles count as zero.
   function automatic logic [MAX_DIGITS-1:0] lead_zero_mask(
      input logic [NIBBLE_W*MAX_DIGITS-1:0] val);
      logic zero_above;
      zero_above     = 1'b1;
      lead_zero_mask = '0;
      for (int i = MAX_DIGITS-1; i >= 0; i--) begin
         zero_above        = zero_above && (val[NIBBLE_W*i +: NIBBLE_W] == '0);
         lead_zero_mask[i] = zero_above;
      end
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler and digit-slot counter for the display scanner; flags the last
// cycle of the last slot as the frame boundary.
module scan_tick_gen #(
   parameter int NDIGITS = 4,
   parameter int DIV     = 50000,
   parameter int PCNT_W  = (DIV > 1) ? $clog2(DIV) : 1,
   parameter int SLOT_W  = $clog2(NDIGITS)
) (
   input  logic              clk,
   input  logic              reset,
   output logic [PCNT_W-1:0] o_pcnt,
   output logic [SLOT_W-1:0] o_slot,
   output logic              o_frame_end
);

   logic [PCNT_W-1:0] r_pcnt;
   logic [SLOT_W-1:0] r_slot;
   logic              w_pcnt_wrap;
   logic              w_slot_wrap;

   assign w_pcnt_wrap = (r_pcnt == PCNT_W'(DIV-1));
   assign w_slot_wrap = (r_slot == SLOT_W'(NDIGITS-1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pcnt <= '0;
         r_slot <= '0;
      end else if (w_pcnt_wrap) begin
         r_pcnt <= '0;
         r_slot <= w_slot_wrap ? '0 : r_slot + SLOT_W'(1);
      end else begin
         r_pcnt <= r_pcnt + PCNT_W'(1);
      end
   end

   assign o_pcnt      = r_pcnt;
   assign o_slot      = r_slot;
   assign o_frame_end = w_pcnt_wrap && w_slot_wrap;

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment scanner: double-buffered frame (pending ->
// display at frame boundary) so a new value never tears mid-frame.
module sevenseg_scan
   import display_pkg::*;
#(
   parameter int NDIGITS       = 4,
   parameter int DIV           = 50000,
   parameter int GUARD         = 8,
   parameter int BLANK_LEADING = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NIBBLE_W*NDIGITS-1:0] in_value,
   input  logic [NDIGITS-1:0]          in_dp,
   output logic [NIBBLE_W-1:0]         digit,
   output logic                        dp,
   output logic                        blank,
   output logic [NDIGITS-1:0]          an
);

   localparam int PCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SLOT_W = $clog2(NDIGITS);
   localparam int VAL_W  = NIBBLE_W*NDIGITS;

   logic [PCNT_W-1:0]           w_pcnt;
   logic [SLOT_W-1:0]           w_slot;
   logic                        w_frame_end;
   logic [2:0]                  w_slot3;
   logic                        w_in_guard;
   logic [MAX_DIGITS-1:0]       w_lz;
   logic [NDIGITS-1:0]          w_sel;

   logic [VAL_W-1:0]            r_disp_val;
   logic [NDIGITS-1:0]          r_disp_dp;
   logic [VAL_W-1:0]            r_pend_val;
   logic [NDIGITS-1:0]          r_pend_dp;
   logic                        r_pend_vld;

   scan_tick_gen #(
      .NDIGITS (NDIGITS),
      .DIV     (DIV),
      .PCNT_W  (PCNT_W),
      .SLOT_W  (SLOT_W)
   ) u_tick (
      .clk         (clk),
      .reset       (reset),
      .o_pcnt      (w_pcnt),
      .o_slot      (w_slot),
      .o_frame_end (w_frame_end)
   );

   // Promotion and accept are exclusive: accept needs pend_vld low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_disp_val <= '0;
         r_disp_dp  <= '0;
         r_pend_val <= '0;
         r_pend_dp  <= '0;
         r_pend_vld <= 1'b0;
      end else if (w_frame_end && r_pend_vld) begin
         r_disp_val <= r_pend_val;
         r_disp_dp  <= r_pend_dp;
         r_pend_vld <= 1'b0;
      end else if (in_valid && !r_pend_vld) begin
         r_pend_val <= in_value;
         r_pend_dp  <= in_dp;
         r_pend_vld <= 1'b1;
      end
   end

   generate
      if (GUARD > 0) begin : g_guard
         assign w_in_guard = (w_pcnt < PCNT_W'(GUARD));
      end else begin : g_noguard
         assign w_in_guard = 1'b0;
      end
   endgenerate

   assign w_slot3 = 3'(w_slot);
   assign w_sel   = NDIGITS'(onehot(w_slot3));
   assign w_lz    = lead_zero_mask((NIBBLE_W*MAX_DIGITS)'(r_disp_val));

   assign in_ready = !r_pend_vld;
   assign an       = w_in_guard ? '0 : w_sel;
   assign digit    = r_disp_val[NIBBLE_W*w_slot +: NIBBLE_W];
   assign dp       = r_disp_dp[w_slot];
   assign blank    = (BLANK_LEADING != 0) && (w_slot != '0) && w_lz[w_slot3];

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench: accepted frames are queued by the stimulus; the monitor
// promotes them at frame boundaries and checks every cycle against a time model.
module tb_sevenseg_scan;

   localparam int ND    = 4;
   localparam int DIV   = 4;
   localparam int GUARD = 1;
   localparam int FRAME = ND*DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_value = '0;
   logic [3:0]  in_dp = '0;

   logic        in_ready, dp, blank;
   logic [3:0]  digit, an;
   logic        in_ready_nb, dp_nb, blank_nb;
   logic [3:0]  digit_nb, an_nb;

   sevenseg_scan #(.NDIGITS(ND), .DIV(DIV), .GUARD(GUARD), .BLANK_LEADING(1)) dut (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_value(in_value), .in_dp(in_dp), .digit(digit), .dp(dp),
      .blank(blank), .an(an));

   sevenseg_scan #(.NDIGITS(ND), .DIV(DIV), .GUARD(GUARD), .BLANK_LEADING(0)) dut_nb (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready_nb),
      .in_value(in_value), .in_dp(in_dp), .digit(digit_nb), .dp(dp_nb),
      .blank(blank_nb), .an(an_nb));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] val;
      logic [3:0]  dp;
      int          edge_n;
   } frame_t;

   frame_t      q[$];
   int          n = 0;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] cur_val = '0;
   logic [3:0]  cur_dp = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, act, exp);
      end
   endtask

   // Monitor: n counts clock edges since reset release.
   initial begin : mon
      logic prev_rst;
      int pc, sl;
      logic [3:0] e_an, e_dig;
      logic e_dp, e_bl, e_rdy;
      prev_rst = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            cur_val  = '0;
            cur_dp   = '0;
            n        = 0;
            prev_rst = 1'b1;
            chk("rst_an", 32'(an), 0);
            chk("rst_digit", 32'(digit), 0);
            chk("rst_dp", 32'(dp), 0);
            chk("rst_blank", 32'(blank), 0);
            chk("rst_in_ready", 32'(in_ready), 1);
            chk("rst_an_nb", 32'(an_nb), 0);
         end else begin
            if (!prev_rst) begin
               n++;
               if (n % FRAME == 0 && q.size() > 0 && q[0].edge_n < n) begin
                  cur_val = q[0].val;
                  cur_dp  = q[0].dp;
                  void'(q.pop_front());
               end
            end
            prev_rst = 1'b0;
            pc    = n % DIV;
            sl    = (n / DIV) % ND;
            e_an  = (pc < GUARD) ? 4'h0 : 4'(1 << sl);
            e_dig = 4'((cur_val >> (4*sl)) & 16'hF);
            e_dp  = cur_dp[sl];
            e_bl  = (sl != 0) && ((cur_val >> (4*sl)) == 16'h0);
            e_rdy = (q.size() == 0);
            chk("an", 32'(an), 32'(e_an));
            chk("digit", 32'(digit), 32'(e_dig));
            chk("dp", 32'(dp), 32'(e_dp));
            chk("blank", 32'(blank), 32'(e_bl));
            chk("in_ready", 32'(in_ready), 32'(e_rdy));
            chk("an_nb", 32'(an_nb), 32'(e_an));
            chk("digit_nb", 32'(digit_nb), 32'(e_dig));
            chk("dp_nb", 32'(dp_nb), 32'(e_dp));
            chk("blank_nb", 32'(blank_nb), 0);
            chk("in_ready_nb", 32'(in_ready_nb), 32'(e_rdy));
         end
      end
   end

   task automatic cycles(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   // Called at posedge+2; the accept happens on the next edge (monitor n+1).
   task automatic send(input logic [15:0] v, input logic [3:0] d);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_value = v;
      in_dp    = d;
      while (!in_ready && w < 200) begin
         cycles(1);
         w++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #2;
      q.push_back('{v, d, n + 1});
      in_valid = 1'b0;
   endtask

   initial begin : stim
      logic [15:0] v;
      logic [3:0]  d;
      int w;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      cycles(3);

      send(16'h1234, 4'h0);  cycles(40);
      send(16'h0050, 4'h0);  cycles(36);
      send(16'h0000, 4'h0);  cycles(36);
      // Second frame is held off until the first is promoted.
      send(16'hABCD, 4'h0);
      send(16'h5678, 4'h3);  cycles(40);
      send(16'h9999, 4'b0100); cycles(40);

      for (int i = 0; i < 30; i++) begin
         v = 16'(16'($urandom) >> $urandom_range(0, 15));
         d = 4'($urandom);
         send(v, d);
         cycles($urandom_range(0, 20));
      end
      cycles(40);

      // Reset while a frame is pending: it must be discarded.
      w = 0;
      while ((n % FRAME) != 2 && w < 100) begin
         cycles(1);
         w++;
      end
      send(16'h4321, 4'h1);
      cycles(2);
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(40);
      send(16'hBEEF, 4'hA);
      cycles(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
